// File: rtl/sobel_pkg.sv
// sobel_pkg: shared defaults, window index helpers and counter-width function
// for the Sobel window generator.
package sobel_pkg;
    localparam int PIX_W_DEF  = 8;
    localparam int WIN_N      = 3;
    localparam int PIX_CENTRE = 4;

    // pix_k sits at k = row*3 + col, row 0 being the oldest line
    function automatic int win_idx(input int row, input int col);
        return row * WIN_N + col;
    endfunction

    function automatic int clog2w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: one-line pixel store, registered write and asynchronous read
// so the old value at an address is visible in the same cycle it is overwritten.
module sobel_line_buf import sobel_pkg::*; #(
    parameter int W     = PIX_W_DEF,
    parameter int DEPTH = 640,
    parameter int AW    = clog2w(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_addr] <= i_wdata;

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streaming 3x3 neighbourhood generator with valid/ready flow
// control, centre coordinates, end-of-frame marker and frame-start checking.
module sobel_window_gen import sobel_pkg::*; #(
    parameter  int PIX_W = PIX_W_DEF,
    parameter  int IMG_W = 640,
    parameter  int IMG_H = 480,
    localparam int XW    = clog2w(IMG_W),
    localparam int YW    = clog2w(IMG_H)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sof,
    input  logic [PIX_W-1:0]   in_pix,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [9*PIX_W-1:0] out_win,
    output logic [XW-1:0]      out_x,
    output logic [YW-1:0]      out_y,
    output logic               out_eof,
    output logic               sof_err
);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0]      r_x, w_px;
    logic [YW-1:0]      r_y, w_py;
    logic [3*PIX_W-1:0] r_col [WIN_N];
    logic [PIX_W-1:0]   w_lb0, w_lb1;
    logic               w_acc, w_emit;

    assign in_ready = !out_valid || out_ready;
    assign w_acc    = in_valid && in_ready;
    assign w_px     = in_sof ? '0 : r_x;
    assign w_py     = in_sof ? '0 : r_y;
    assign w_emit   = w_acc && (w_px >= XW'(2)) && (w_py >= YW'(2));

    sobel_line_buf #(.W(PIX_W), .DEPTH(IMG_W), .AW(XW)) u_lb0 (
        .clk(clk), .i_we(w_acc), .i_addr(w_px), .i_wdata(in_pix), .o_rdata(w_lb0)
    );
    sobel_line_buf #(.W(PIX_W), .DEPTH(IMG_W), .AW(XW)) u_lb1 (
        .clk(clk), .i_we(w_acc), .i_addr(w_px), .i_wdata(w_lb0), .o_rdata(w_lb1)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_col     <= '{default: '0};
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_eof   <= 1'b0;
            sof_err   <= 1'b0;
        end else begin
            sof_err <= w_acc && in_sof && (r_x != '0 || r_y != '0);
            if (w_acc) begin
                r_x   <= (w_px == X_LAST) ? '0 : w_px + XW'(1);
                r_y   <= (w_px != X_LAST) ? w_py : (w_py == Y_LAST) ? '0 : w_py + YW'(1);
                r_col <= '{r_col[1], r_col[2], {in_pix, w_lb0, w_lb1}};
            end
            if (w_emit) begin
                out_x   <= w_px - XW'(1);
                out_y   <= w_py - YW'(1);
                out_eof <= (w_px == X_LAST) && (w_py == Y_LAST);
            end
            out_valid <= w_emit || (out_valid && !out_ready);
        end

    // Columns only move on accept, and accept is blocked while stalled, so the
    // window can be read straight from the column registers.
    for (genvar r = 0; r < WIN_N; r++) begin : g_row
        for (genvar c = 0; c < WIN_N; c++) begin : g_col
            assign out_win[win_idx(r, c)*PIX_W +: PIX_W] = r_col[c][r*PIX_W +: PIX_W];
        end
    end
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed checks on a 4x3 8-bit instance and a randomly
// throttled 5x4 12-bit instance of the window generator.
module tb_sobel_window_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_in_sof, a_out_valid, a_out_ready, a_out_eof, a_sof_err;
    logic [7:0]  a_in_pix;
    logic [71:0] a_out_win;
    logic [1:0]  a_out_x, a_out_y;

    logic         b_in_valid, b_in_ready, b_in_sof, b_out_valid, b_out_ready, b_out_eof, b_sof_err;
    logic [11:0]  b_in_pix;
    logic [107:0] b_out_win;
    logic [2:0]   b_out_x;
    logic [1:0]   b_out_y;

    sobel_window_gen #(.PIX_W(8), .IMG_W(4), .IMG_H(3)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sof(a_in_sof),
        .in_pix(a_in_pix), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_win(a_out_win),
        .out_x(a_out_x), .out_y(a_out_y), .out_eof(a_out_eof), .sof_err(a_sof_err)
    );

    sobel_window_gen #(.PIX_W(12), .IMG_W(5), .IMG_H(4)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sof(b_in_sof),
        .in_pix(b_in_pix), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_win(b_out_win),
        .out_x(b_out_x), .out_y(b_out_y), .out_eof(b_out_eof), .sof_err(b_sof_err)
    );

    int errors = 0;
    int checks = 0;

    localparam logic [71:0] W1 = 72'h0A_09_08_06_05_04_02_01_00;
    localparam logic [71:0] W2 = 72'h0B_0A_09_07_06_05_03_02_01;
    logic [71:0] exp_win [2] = '{W1, W2};
    logic [1:0]  exp_x   [2] = '{2'd1, 2'd2};
    logic        exp_eof [2] = '{1'b0, 1'b1};

    logic [71:0]  qa_win [$];
    logic [1:0]   qa_x [$], qa_y [$];
    logic         qa_eof [$];
    int           a_sof_cnt;
    logic [107:0] qb_win [$];
    logic [2:0]   qb_x [$];
    logic [1:0]   qb_y [$];
    logic         qb_eof [$];
    int           b_sof_cnt;
    logic [11:0]  img [20];
    bit           b_done;

    // Transfers are recorded just before the rising edge that completes them.
    always @(negedge clk) begin
        #4;
        if (!rst && a_out_valid && a_out_ready) begin
            qa_win.push_back(a_out_win);
            qa_x.push_back(a_out_x);
            qa_y.push_back(a_out_y);
            qa_eof.push_back(a_out_eof);
        end
        if (!rst && a_sof_err) a_sof_cnt++;
        if (!rst && b_out_valid && b_out_ready) begin
            qb_win.push_back(b_out_win);
            qb_x.push_back(b_out_x);
            qb_y.push_back(b_out_y);
            qb_eof.push_back(b_out_eof);
        end
        if (!rst && b_sof_err) b_sof_cnt++;
    end

    task automatic clear_a();
        qa_win.delete(); qa_x.delete(); qa_y.delete(); qa_eof.delete();
        a_sof_cnt = 0;
    endtask

    task automatic send_a(input logic [7:0] p, input logic sof);
        int n;
        n = 0;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_pix = p; a_in_sof = sof;
        #1;
        while (!a_in_ready && n < 50) begin @(negedge clk); #1; n++; end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL send_a timeout: in_ready stuck at %b for pixel %0d", a_in_ready, p);
        end
        @(posedge clk);
    endtask

    task automatic idle_a();
        @(negedge clk);
        a_in_valid = 1'b0; a_in_sof = 1'b0;
    endtask

    task automatic send_frame_a(input logic sof_first);
        for (int i = 0; i < 12; i++) send_a(8'(i), sof_first && i == 0);
        idle_a();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 0; a_in_sof = 0; a_in_pix = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_sof = 0; b_in_pix = 0; b_out_ready = 1;
        a_sof_cnt = 0; b_sof_cnt = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_out_valid); end
        checks++; if (a_out_win !== 72'h0) begin errors++; $display("FAIL reset_win: got %h want 0", a_out_win); end
        checks++; if (a_out_x !== 2'd0 || a_out_y !== 2'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", a_out_x, a_out_y); end
        checks++; if (a_out_eof !== 1'b0 || a_sof_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got eof=%b sof_err=%b want 0,0", a_out_eof, a_sof_err); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", a_in_ready); end
        checks++; if (b_out_valid !== 1'b0 || b_out_win !== 108'h0) begin errors++; $display("FAIL reset_b: got valid=%b win=%h want 0", b_out_valid, b_out_win); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        clear_a();
        send_frame_a(1'b1);
        repeat (4) @(negedge clk);
        checks++; if (qa_win.size() !== 2) begin errors++; $display("FAIL basic_count: got %0d windows want 2", qa_win.size()); end
        for (int i = 0; i < qa_win.size() && i < 2; i++) begin
            checks++;
            if (qa_win[i] !== exp_win[i] || qa_x[i] !== exp_x[i] || qa_y[i] !== 2'd1 || qa_eof[i] !== exp_eof[i]) begin
                errors++;
                $display("FAIL basic_win%0d: got %h x=%0d y=%0d eof=%b want %h x=%0d y=1 eof=%b",
                         i, qa_win[i], qa_x[i], qa_y[i], qa_eof[i], exp_win[i], exp_x[i], exp_eof[i]);
            end
        end
        checks++; if (a_sof_cnt !== 0) begin errors++; $display("FAIL basic_sof_err: got %0d pulses want 0", a_sof_cnt); end
    endtask

    task automatic test_stall();
        clear_a();
        fork
            send_frame_a(1'b1);
            begin : stall
                int n;
                logic [71:0] snap;
                logic [1:0] sx, sy;
                logic se;
                n = 0;
                @(negedge clk);
                while (!a_out_valid && n < 100) begin @(negedge clk); n++; end
                if (n == 100) begin
                    checks++; errors++;
                    $display("FAIL stall_wait: out_valid got %b want 1 within 100 cycles", a_out_valid);
                end
                a_out_ready = 1'b0;
                snap = a_out_win; sx = a_out_x; sy = a_out_y; se = a_out_eof;
                repeat (5) begin
                    #1;
                    checks++;
                    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_win !== snap ||
                        a_out_x !== sx || a_out_y !== sy || a_out_eof !== se) begin
                        errors++;
                        $display("FAIL stall_hold: got ready=%b valid=%b win=%h x=%0d y=%0d want ready=0 valid=1 win=%h x=%0d y=%0d",
                                 a_in_ready, a_out_valid, a_out_win, a_out_x, a_out_y, snap, sx, sy);
                    end
                    @(negedge clk);
                end
                a_out_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        checks++; if (qa_win.size() !== 2) begin errors++; $display("FAIL stall_count: got %0d windows want 2", qa_win.size()); end
        for (int i = 0; i < qa_win.size() && i < 2; i++) begin
            checks++;
            if (qa_win[i] !== exp_win[i] || qa_x[i] !== exp_x[i] || qa_y[i] !== 2'd1 || qa_eof[i] !== exp_eof[i]) begin
                errors++;
                $display("FAIL stall_win%0d: got %h x=%0d y=%0d eof=%b want %h x=%0d y=1 eof=%b",
                         i, qa_win[i], qa_x[i], qa_y[i], qa_eof[i], exp_win[i], exp_x[i], exp_eof[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_a();
        for (int i = 0; i < 24; i++) send_a(8'(i % 12), i == 0);
        idle_a();
        repeat (4) @(negedge clk);
        checks++; if (qa_win.size() !== 4) begin errors++; $display("FAIL b2b_count: got %0d windows want 4", qa_win.size()); end
        for (int i = 0; i < qa_win.size() && i < 4; i++) begin
            checks++;
            if (qa_win[i] !== exp_win[i%2] || qa_x[i] !== exp_x[i%2] || qa_y[i] !== 2'd1 || qa_eof[i] !== exp_eof[i%2]) begin
                errors++;
                $display("FAIL b2b_win%0d: got %h x=%0d y=%0d eof=%b want %h x=%0d y=1 eof=%b",
                         i, qa_win[i], qa_x[i], qa_y[i], qa_eof[i], exp_win[i%2], exp_x[i%2], exp_eof[i%2]);
            end
        end
        checks++; if (a_sof_cnt !== 0) begin errors++; $display("FAIL b2b_sof_err: got %0d pulses want 0", a_sof_cnt); end
    endtask

    task automatic test_sof_mid();
        clear_a();
        for (int i = 0; i < 6; i++) send_a(8'(i), i == 0);
        send_frame_a(1'b1);
        repeat (4) @(negedge clk);
        checks++; if (a_sof_cnt !== 1) begin errors++; $display("FAIL sofmid_pulses: got %0d want 1", a_sof_cnt); end
        checks++; if (qa_win.size() !== 2) begin errors++; $display("FAIL sofmid_count: got %0d windows want 2", qa_win.size()); end
        for (int i = 0; i < qa_win.size() && i < 2; i++) begin
            checks++;
            if (qa_win[i] !== exp_win[i] || qa_x[i] !== exp_x[i] || qa_y[i] !== 2'd1 || qa_eof[i] !== exp_eof[i]) begin
                errors++;
                $display("FAIL sofmid_win%0d: got %h x=%0d y=%0d eof=%b want %h x=%0d y=1 eof=%b",
                         i, qa_win[i], qa_x[i], qa_y[i], qa_eof[i], exp_win[i], exp_x[i], exp_eof[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_a();
        for (int i = 0; i < 7; i++) send_a(8'(i), i == 0);
        @(negedge clk);
        a_in_valid = 1'b1; a_in_pix = 8'd7; a_in_sof = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_win !== 72'h0 || a_out_x !== 2'd0 || a_out_y !== 2'd0 || a_out_eof !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got valid=%b win=%h x=%0d y=%0d eof=%b want all 0",
                     a_out_valid, a_out_win, a_out_x, a_out_y, a_out_eof);
        end
        @(negedge clk);
        rst = 1'b0; a_in_valid = 1'b0;
        send_frame_a(1'b0);
        repeat (4) @(negedge clk);
        checks++; if (qa_win.size() !== 2) begin errors++; $display("FAIL rstmid_count: got %0d windows want 2", qa_win.size()); end
        for (int i = 0; i < qa_win.size() && i < 2; i++) begin
            checks++;
            if (qa_win[i] !== exp_win[i] || qa_x[i] !== exp_x[i] || qa_y[i] !== 2'd1 || qa_eof[i] !== exp_eof[i]) begin
                errors++;
                $display("FAIL rstmid_win%0d: got %h x=%0d y=%0d eof=%b want %h x=%0d y=1 eof=%b",
                         i, qa_win[i], qa_x[i], qa_y[i], qa_eof[i], exp_win[i], exp_x[i], exp_eof[i]);
            end
        end
        checks++; if (a_sof_cnt !== 0) begin errors++; $display("FAIL rstmid_sof_err: got %0d pulses want 0", a_sof_cnt); end
    endtask

    task automatic send_b(input logic [11:0] p, input logic sof);
        int n;
        n = 0;
        repeat ($urandom_range(0, 2)) begin @(negedge clk); b_in_valid = 1'b0; end
        @(negedge clk);
        b_in_valid = 1'b1; b_in_pix = p; b_in_sof = sof;
        #1;
        while (!b_in_ready && n < 50) begin @(negedge clk); #1; n++; end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL send_b timeout: in_ready stuck at %b for pixel %h", b_in_ready, p);
        end
        @(posedge clk);
    endtask

    task automatic test_random();
        logic [107:0] w;
        int cx, cy;
        for (int i = 0; i < 20; i++) img[i] = 12'($urandom);
        b_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) send_b(img[i], i == 0);
                @(negedge clk);
                b_in_valid = 1'b0; b_in_sof = 1'b0;
                b_done = 1'b1;
            end
            begin
                while (!b_done) begin @(negedge clk); b_out_ready = 1'($urandom_range(0, 1)); end
                b_out_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        checks++; if (qb_win.size() !== 6) begin errors++; $display("FAIL rand_count: got %0d windows want 6", qb_win.size()); end
        for (int k = 0; k < qb_win.size() && k < 6; k++) begin
            cy = 1 + k / 3;
            cx = 1 + k % 3;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[(r*3+c)*12 +: 12] = img[(cy-1+r)*5 + cx-1+c];
            checks++;
            if (qb_win[k] !== w || qb_x[k] !== 3'(cx) || qb_y[k] !== 2'(cy) || qb_eof[k] !== (cx == 3 && cy == 2)) begin
                errors++;
                $display("FAIL rand_win%0d: got %h x=%0d y=%0d eof=%b want %h x=%0d y=%0d eof=%b",
                         k, qb_win[k], qb_x[k], qb_y[k], qb_eof[k], w, cx, cy, (cx == 3 && cy == 2));
            end
        end
        checks++; if (b_sof_cnt !== 0) begin errors++; $display("FAIL rand_sof_err: got %0d pulses want 0", b_sof_cnt); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_sof_mid();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Parametrised streaming 3x3 neighbourhood generator feeding the Sobel datapath.
- Accepts a raster-order pixel stream with valid/ready handshake and frame-start marker.
- Holds the two previous lines in internal line buffers and emits every fully-interior 3x3 window with its centre coordinates, under output back-pressure.
- Generalises the fixed-size 8-bit window source to arbitrary pixel width and image size. Adds flow control, coordinates and frame-sync checking.

Parameters:
- PIX_W, 8, bits per pixel.
- IMG_W, 640, pixels per line; legal range 3 and up.
- IMG_H, 480, lines per frame; legal range 3 and up.
- XW, clog2(IMG_W), column counter width (derived localparam).
- YW, clog2(IMG_H), row counter width (derived localparam).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input pixel present.
- in_ready  out  1  block can accept a pixel this cycle.
- in_sof  in  1  qualifies the current input pixel as frame pixel (0,0).
- in_pix  in  PIX_W  input pixel, raster order.
- out_valid  out  1  window present.
- out_ready  in  1  consumer accepts the window.
- out_win  out  9*PIX_W  window; pix_k is at [k*PIX_W +: PIX_W], with k = row*3 + col.
- out_x  out  XW  window centre column.
- out_y  out  YW  window centre row.
- out_eof  out  1  marks the last window of the frame.
- sof_err  out  1  one-cycle pulse: in_sof arrived at a position other than (0,0).

Behaviour:
- Reset (async assert): out_valid=0, out_win=0, out_x=0, out_y=0, out_eof=0, sof_err=0, pixel position (x,y)=(0,0), window columns cleared.
  - Line buffer contents are don't-care; they are never emitted before being rewritten.
  - Reset mid-frame discards the partial frame and any pending window.
- Handshake:
  - in_ready = !out_valid || out_ready (single-entry output register, combinational ready).
  - Accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_* are held stable while out_valid && !out_ready.
- Position tracking, on each accept:
  - If in_sof: the pixel is treated as (0,0). If the current position was not (0,0), pulse sof_err on the next cycle.
  - After the pixel, x increments. At IMG_W-1, x wraps to 0 and y increments. At (IMG_W-1, IMG_H-1), the position wraps to (0,0) without requiring in_sof.
- Line buffers:
  - lb0 holds line y-1 and lb1 holds line y-2, each IMG_W entries.
  - On accept at column x: read lb0[x] and lb1[x] (old values, read-before-write), then write lb1[x]<=lb0[x] and lb0[x]<=in_pix.
- Window:
  - Three column registers shift left on accept; the new right column is {lb1[x], lb0[x], in_pix} for rows 0,1,2.
  - Row 0 is top (y-2), col 0 is left (x-2), pix_4 is the centre.
- Emission:
  - If the accepted pixel has x>=2 and y>=2, the next cycle sets out_valid=1 with the shifted window, out_x=x-1, out_y=y-1.
  - out_eof=1 iff x=IMG_W-1 and y=IMG_H-1.
  - Otherwise out_valid clears after a transfer.
  - Latency is 1 cycle from accept to out_valid.
  - Windows per frame = (IMG_W-2)*(IMG_H-2). No windows straddle a line wrap: x<2 suppresses them.
- Simultaneous output transfer and accept of a new window-producing pixel: out_valid stays 1 with the new data, so there is no bubble at full throughput.
- Pixel values pass through unmodified; no arithmetic on pixel data.

Decomposition:
- Shared package sobel_pkg:
  - PIX_W default.
  - window index constants for the pix_0..pix_8 positions.
  - helper function for the clog2 width.
- Natural sub-module: sobel_line_buf. A single-port-style IMG_W x PIX_W array with registered write and async read, with the read-before-write rule above. It is instantiated twice.

Test Plan:
- IMG_W=4, IMG_H=3, pixel=y*4+x, in_valid constant, out_ready=1, in_sof on the first pixel -> exactly 2 windows:
  - Window 1 at (1,1): pix_0..pix_8 = 0,1,2,4,5,6,8,9,10, out_eof=0.
  - Window 2 at (2,1): pix_0..pix_8 = 1,2,3,5,6,7,9,10,11, out_eof=1.
- Same stream, with out_ready held 0 for 5 cycles once the first window is valid:
  - in_ready=0 throughout the hold and out_* are stable.
  - After release, both windows arrive in order with no loss or duplication.
- Two back-to-back frames without a second in_sof -> the second frame yields identical windows, with no sof_err.
- in_sof asserted at pixel (2,1) -> sof_err pulses once, and the following windows are referenced to the new (0,0).
- rst asserted for 1 cycle at pixel (3,1), then a full frame is sent -> outputs are 0 during reset and the frame yields the 2 correct windows.
- PIX_W=12, IMG_W=5, IMG_H=4, with random in_valid/out_ready -> 6 windows matching a software reference model, with out_eof on centre (3,2).
